// File: rtl/neo_pkg.sv
// Shared definitions for the NeoPixel link: FSM states, pixel layout and
// 50 MHz timing constants used by both the receiver and the strand controller.
package neo_pkg;

    // Bit-cell timing at 50 MHz (cycles): 0-bit and 1-bit high/low widths
    localparam int T0H_CYCLES = 18;
    localparam int T0L_CYCLES = 40;
    localparam int T1H_CYCLES = 35;
    localparam int T1L_CYCLES = 30;

    // Receiver decode limits (cycles)
    localparam int MIN_HIGH_CYCLES    = 8;
    localparam int HIGH_THRESH_CYCLES = 26;
    localparam int MAX_HIGH_CYCLES    = 50;
    localparam int LATCH_GAP_CYCLES   = 2500;   // 50 us frame-end gap

    localparam int WORD_BITS = 24;
    localparam int RUN_W     = 12;              // holds LATCH_GAP_CYCLES
    localparam int IDX_W     = 3;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        HIGH,
        LOW
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/neo_pulse_meter.sv
// Line front end: two-flop synchronizer, edge detect and a run-length counter
// that reports how many cycles the synced line has held its current level.
module neo_pulse_meter
    import neo_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             neo_in,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [RUN_W-1:0] run_len
);

    logic sync_a;
    logic sync_b;

    // Bring the asynchronous line into the clock domain
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= neo_in;
            sync_b <= sync_a;
        end
    end

    // Track the previous level and the length of its run (saturating)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level   <= 1'b0;
            run_len <= '0;
        end else begin
            level <= sync_b;
            if (sync_b != level)
                run_len <= RUN_W'(1);
            else if (run_len != '1)
                run_len <= run_len + RUN_W'(1);
        end
    end

    // run_len is the full width of the run that ends on these edges
    assign rise = sync_b & ~level;
    assign fall = ~sync_b & level;

endmodule

// File: rtl/neo_pixel_receiver.sv
// NeoPixel receiver: decodes high-pulse widths into bits, assembles 24-bit
// {G,R,B} words and presents them on a valid/ready port with the pixel index.
// Optional feature macro NEO_FORWARD_EN: pass excess words downstream on neo_out.
module neo_pixel_receiver
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS   = 5,
    parameter int MIN_HIGH     = MIN_HIGH_CYCLES,
    parameter int HIGH_THRESH  = HIGH_THRESH_CYCLES,
    parameter int MAX_HIGH     = MAX_HIGH_CYCLES,
    parameter int LATCH_CYCLES = LATCH_GAP_CYCLES
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_in,
    input  logic        pixel_ready,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [2:0]  pixel_index,
    output logic        frame_done,
    output logic [2:0]  frame_count,
    output logic        overflow,
    output logic        error,
    output logic        neo_out
);

    localparam logic [RUN_W-1:0]     MIN_L    = RUN_W'(MIN_HIGH);
    localparam logic [RUN_W-1:0]     THRESH_L = RUN_W'(HIGH_THRESH);
    localparam logic [RUN_W-1:0]     MAX_L    = RUN_W'(MAX_HIGH);
    localparam logic [RUN_W-1:0]     LATCH_L  = RUN_W'(LATCH_CYCLES);
    localparam logic [IDX_W-1:0]     FULL_IDX = IDX_W'(NUM_PIXELS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   level;
    logic                   rise;
    logic                   fall;
    logic [RUN_W-1:0]       run_len;
    logic                   long_low;
    logic                   bit_take;
    logic                   pulse_fail;
    logic                   latch_hit;
    logic [WORD_BITS-1:0]   shift_q;
    logic [WORD_BITS-1:0]   shift_next;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]       pix_idx;
    pixel_t                 word_q;

    neo_pulse_meter u_meter (
        .clock   (clock),
        .reset   (reset),
        .neo_in  (neo_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .run_len (run_len)
    );

    assign long_low   = !level && (run_len >= LATCH_L);
    // First received bit ends up in bit 0 after 24 shifts
    assign shift_next = {(run_len >= THRESH_L), shift_q[WORD_BITS-1:1]};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RESYNC;
        else       state <= state_next;
    end

    // Next state and per-cycle decode strobes
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next = state;
        bit_take   = 1'b0;
        pulse_fail = 1'b0;
        latch_hit  = 1'b0;
        case (state)
            RESYNC: if (long_low) state_next = IDLE;
            IDLE:   if (rise)     state_next = HIGH;
            HIGH: begin
                if (run_len > MAX_L) begin
                    pulse_fail = 1'b1;
                    state_next = RESYNC;
                end else if (fall) begin
                    if (run_len < MIN_L) begin
                        pulse_fail = 1'b1;
                        state_next = RESYNC;
                    end else begin
                        bit_take   = 1'b1;
                        state_next = LOW;
                    end
                end
            end
            LOW: begin
                if (long_low) begin
                    latch_hit  = 1'b1;
                    state_next = IDLE;
                end else if (rise) begin
                    state_next = HIGH;
                end
            end
            default: state_next = RESYNC;
        endcase
    end

    // Shift register, word assembly, output buffer and status pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            pix_idx     <= '0;
            word_q      <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            error       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            error      <= 1'b0;
            if (pixel_valid && pixel_ready)
                pixel_valid <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                pix_idx <= '0;
            end
            if (pulse_fail)
                error <= 1'b1;
            if (latch_hit) begin
                frame_done  <= 1'b1;
                frame_count <= pix_idx;
                bit_cnt     <= '0;
                if (bit_cnt != '0)
                    error <= 1'b1;   // partial word dropped
            end
            if (bit_take) begin
                shift_q <= shift_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (pix_idx == FULL_IDX) begin
`ifdef NEO_FORWARD_EN
                        // excess words travel downstream on neo_out instead
`else
                        error <= 1'b1;
`endif
                    end else begin
                        pix_idx <= pix_idx + IDX_W'(1);
                        if (pixel_valid && !pixel_ready) begin
                            overflow <= 1'b1;
                        end else begin
                            pixel_valid <= 1'b1;
                            word_q      <= pixel_t'(shift_next);
                            pixel_index <= pix_idx;
                        end
                    end
                end else begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    assign pixel_data = word_q;

`ifdef NEO_FORWARD_EN
    // Once this receiver is full, repeat the synced line downstream
    always_ff @(posedge clock or posedge reset) begin
        if (reset) neo_out <= 1'b0;
        else       neo_out <= (pix_idx == FULL_IDX) && level;
    end
`else
    assign neo_out = 1'b0;
`endif

endmodule
